pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 103 ++++++++++
 rtl/pipe_stage.sv | 77 +++++++
 tb/tb_pipe_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control encodings,
// skid-buffer state encoding and the default bubble payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    GO    = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    RSVD  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } skid_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: head register plus one parked entry, so ready_o
// depends only on registered state and never on ready_i.
//
//   state | meaning
//   EMPTY | no entry held, occ 0
//   FULL  | head valid, occ 1
//   SKID  | head valid plus one parked entry, occ 2, upstream blocked
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_W  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctrl_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  skid_state_e       state_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] park_q;
  logic              valid_q;
  logic [1:0]        occ_q;
  logic              go;
  logic              flush;
  logic              accept;
  logic              rel;

  assign go      = (ctrl_i == GO);
  assign flush   = (ctrl_i == FLUSH);
  assign ready_o = go && (state_q != SKID);
  assign accept  = valid_i && ready_o;
  assign rel     = go && valid_q && ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= NOP_W;
      park_q  <= NOP_W;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
    end else if (flush) begin
      state_q <= EMPTY;
      head_q  <= NOP_W;
      park_q  <= NOP_W;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            head_q  <= data_i;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        FULL: begin
          if (accept && rel) begin
            head_q <= data_i;
          end else if (accept) begin
            state_q <= SKID;
            park_q  <= data_i;
            occ_q   <= 2'd2;
          end else if (rel) begin
            state_q <= EMPTY;
            head_q  <= NOP_W;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
          end
        end
        SKID: begin
          // the parked entry is older than anything upstream, so it becomes head
          if (rel) begin
            state_q <= FULL;
            head_q  <= park_q;
            park_q  <= NOP_W;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= EMPTY;
          head_q  <= NOP_W;
          park_q  <= NOP_W;
          valid_q <= 1'b0;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with GO/STALL/FLUSH control. Define
// PIPE_STAGE_SKID_EN for the two-entry skid variant; default is single-entry.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] NOP_VAL = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctrl_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [1:0]        occ_o
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_VAL);

`ifdef PIPE_STAGE_SKID_EN

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .NOP_W  (NOP_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .ctrl_i  (ctrl_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_i (ready_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .occ_o   (occ_o)
  );

`else

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              go;
  logic              accept;
  logic              rel;

  assign go      = (ctrl_i == GO);
  // ready_i passes straight through: a same-cycle release frees the slot
  assign ready_o = go && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;
  assign rel     = go && valid_q && ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_W;
    end else if (ctrl_i == FLUSH) begin
      valid_q <= 1'b0;
      data_q  <= NOP_W;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (rel) begin
      valid_q <= 1'b0;
      data_q  <= NOP_W;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign occ_o   = {1'b0, valid_q};

`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  ctrl_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic [1:0]  occ_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_q[$];

  pipe_stage dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_i  (ctrl_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .occ_o   (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    int n;
    n = ref_q.size();
    chk({tag, ".valid"}, {31'd0, valid_o}, (n > 0) ? 32'd1 : 32'd0);
    chk({tag, ".occ"}, {30'd0, occ_o}, n);
    chk({tag, ".data"}, data_o, (n > 0) ? ref_q[0] : 32'd0);
  endtask

  // One clock of traffic: drive, check ready, advance model on the edge, check outputs.
  task automatic step(input logic [1:0] c, input logic v, input logic [31:0] d, input logic r);
    logic go, exp_rdy;
    int n;
    ctrl_i  = c;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    #1;
    go = (c == 2'b00);
    n  = ref_q.size();
    exp_rdy = go && ((CAP == 2) ? (n < 2) : (n == 0 || r));
    chk("ready", {31'd0, ready_o}, {31'd0, exp_rdy});
    @(posedge clk);
    if (c == 2'b10) begin
      ref_q.delete();
    end else if (go) begin
      if (n > 0 && r) void'(ref_q.pop_front());
      if (v && exp_rdy) ref_q.push_back(d);
    end
    #1;
    chk_outputs("out");
  endtask

  task automatic stall_test(input logic [1:0] c, input string tag);
    step(2'b00, 1'b1, 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(c, 1'b1, 32'd8, 1'b1);
      chk({tag, ".data7"}, data_o, 32'd7);
      chk({tag, ".occ1"}, {30'd0, occ_o}, 32'd1);
    end
    step(2'b00, 1'b0, 32'd0, 1'b1);
    chk({tag, ".drain"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    ctrl_i  = 2'b00;
    valid_i = 1'b1;
    data_i  = 32'hDEAD_BEEF;
    ready_i = 1'b1;

    // reset held with an upstream entry present
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.data", data_o, 32'd0);
    chk("rst.occ", {30'd0, occ_o}, 32'd0);
    chk("rst.ready", {31'd0, ready_o}, 32'd1);
    #3 rst = 1'b1;
    step(2'b00, 1'b0, 32'd0, 1'b1);
    chk("rst.after", {31'd0, valid_o}, 32'd0);

    // streaming 1..4, one cycle latency, no gaps
    for (int k = 1; k <= 4; k++) begin
      step(2'b00, 1'b1, k, 1'b1);
      chk("stream", data_o, k);
    end
    step(2'b00, 1'b0, 32'd0, 1'b1);

    // backpressure while sending 5, 6, then drain
    step(2'b00, 1'b1, 32'd5, 1'b0);
    step(2'b00, 1'b1, 32'd6, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp.occ2", {30'd0, occ_o}, 32'd2);
    #1 chk("bp.rdy0", {31'd0, ready_o}, 32'd0);
`endif
    step(2'b00, 1'b0, 32'd0, 1'b1);
    step(2'b00, 1'b0, 32'd0, 1'b1);
    step(2'b00, 1'b0, 32'd0, 1'b1);

    stall_test(2'b01, "stall");
    stall_test(2'b11, "rsvd");

    // flush with full stage and an incoming entry that must be dropped
    step(2'b00, 1'b1, 32'd10, 1'b0);
    step(2'b00, 1'b1, 32'd11, 1'b0);
    step(2'b10, 1'b1, 32'd9, 1'b1);
    chk("flush.valid", {31'd0, valid_o}, 32'd0);
    chk("flush.occ", {30'd0, occ_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b0, 32'd0, 1'b1);
      chk("flush.no9", {31'd0, (data_o == 32'd9)}, 32'd0);
    end

    // asynchronous reset mid-transfer
    step(2'b00, 1'b1, 32'hA, 1'b0);
    step(2'b00, 1'b1, 32'hB, 1'b0);
    #2 rst = 1'b0;
    #1;
    ref_q.delete();
    chk_outputs("amid");
    @(posedge clk);
    #3 rst = 1'b1;
    step(2'b00, 1'b0, 32'd0, 1'b1);
    step(2'b00, 1'b0, 32'd0, 1'b1);
    chk("amid.empty", {31'd0, valid_o}, 32'd0);

    // random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      step(c, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
